// File: rtl/multicore_in_dispatch.sv
// Input dispatcher: host samples are buffered in a first-word-fall-through FIFO and handed out
// round-robin to NCORES cores over a shared io_in bus. Release timeout enabled by MULTICORE_IN_TIMEOUT_EN.
module multicore_in_dispatch #(
   parameter int NCORES     = 25,
   parameter int DW         = 19,
   parameter int FIFO_DEPTH = 16,
   parameter int HOLD       = 2,
   parameter int TIMEOUT    = 64
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic signed [DW-1:0]        in_data,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [4*NCORES-1:0]         req_flat,
   output logic signed [DW-1:0]        io_in,
   output logic [NCORES-1:0]           in_ack,
   output logic [3:0]                  in_port,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level,
   output logic                        busy,
   output logic                        timeout_err
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int IW = (NCORES > 1) ? $clog2(NCORES) : 1;
   localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;

   typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

   if (NCORES < 1 || NCORES > 32 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
       HOLD < 1 || TIMEOUT < 1) begin : g_param_check
      $error("multicore_in_dispatch: illegal parameter set");
   end

   logic signed [DW-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]        wr_ptr, rd_ptr;
   logic [AW:0]          count;
   logic                 push, pop;

   assign in_ready   = (count != (AW+1)'(FIFO_DEPTH));
   assign fifo_level = count;
   assign push       = in_valid && in_ready;

   // NOTE: non-blocking assignments in clocked blocks so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + (AW+1)'(push) - (AW+1)'(pop);
      end
   end

   // NOTE: sample storage is not reset; the pointers and count alone decide what is valid.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= in_data;
   end

   logic [NCORES-1:0] req_any;
   for (genvar k = 0; k < NCORES; k++) begin : g_req
      assign req_any[k] = |req_flat[4*k +: 4];
   end

   function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] base, input int offs);
      int s;
      s = int'(base) + offs;
      if (s >= NCORES) s = s - NCORES;
      return IW'(s);
   endfunction

   state_t            state, state_d;
   logic [IW-1:0]     ptr, cur, win_idx, nxt_ptr;
   logic [NCORES-1:0] win_onehot;
   logic [HW-1:0]     hold_cnt;
   logic              win_found, grant, hold_last, rel_done, cur_req, tmo_hit;

   // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
   always_comb begin
      win_found = 1'b0;
      win_idx   = ptr;
      // Scan downward so the last hit is the nearest requester at or after ptr.
      for (int i = NCORES - 1; i >= 0; i--) begin
         if (req_any[wrap_idx(ptr, i)]) begin
            win_found = 1'b1;
            win_idx   = wrap_idx(ptr, i);
         end
      end
      win_onehot          = '0;
      win_onehot[win_idx] = 1'b1;
   end

   assign cur_req = |req_flat[4*int'(cur) +: 4];
   assign nxt_ptr = (cur == IW'(NCORES - 1)) ? '0 : cur + 1'b1;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_d;
   end

   always_comb begin
      state_d   = state;
      grant     = 1'b0;
      hold_last = 1'b0;
      rel_done  = 1'b0;
      case (state)
         IDLE: begin
            if (win_found && count != '0) begin
               grant   = 1'b1;
               state_d = GRANT;
            end
         end
         GRANT: begin
            if (hold_cnt == HW'(HOLD - 1)) begin
               hold_last = 1'b1;
               state_d   = RELEASE;
            end
         end
         RELEASE: begin
            if (!cur_req || tmo_hit) begin
               rel_done = 1'b1;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign pop  = grant;
   assign busy = (state != IDLE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr      <= '0;
         cur      <= '0;
         hold_cnt <= '0;
         io_in    <= '0;
         in_ack   <= '0;
         in_port  <= '0;
      end else begin
         if (grant) begin
            io_in    <= mem[rd_ptr];
            in_port  <= req_flat[4*int'(win_idx) +: 4];
            in_ack   <= win_onehot;
            cur      <= win_idx;
            hold_cnt <= '0;
         end else if (state == GRANT) begin
            if (hold_last) in_ack   <= '0;
            else           hold_cnt <= hold_cnt + 1'b1;
         end
         if (rel_done) ptr <= nxt_ptr;
      end
   end

`ifdef MULTICORE_IN_TIMEOUT_EN
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   logic [TW-1:0] tmo_cnt;

   // The counter sits at zero outside RELEASE, so tmo_hit marks the TIMEOUT-th release cycle.
   assign tmo_hit = (state == RELEASE) && (tmo_cnt == TW'(TIMEOUT - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tmo_cnt     <= '0;
         timeout_err <= 1'b0;
      end else begin
         if (state != RELEASE) tmo_cnt <= '0;
         else if (!tmo_hit)    tmo_cnt <= tmo_cnt + 1'b1;
         if (tmo_hit && cur_req) timeout_err <= 1'b1;
      end
   end
`else
   assign tmo_hit     = 1'b0;
   assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_multicore_in_dispatch.sv
// Scoreboard bench for multicore_in_dispatch: a queue-based FIFO model plus round-robin order
// computed from request distances feeds an expected-grant queue checked by an independent monitor.
module tb_multicore_in_dispatch;
   localparam int NCORES     = 25;
   localparam int DW         = 19;
   localparam int FIFO_DEPTH = 16;
   localparam int HOLD       = 2;
   localparam int TIMEOUT    = 64;

   logic                        clk = 1'b0;
   logic                        rst = 1'b0;
   logic signed [DW-1:0]        in_data = '0;
   logic                        in_valid = 1'b0;
   logic                        in_ready;
   logic [4*NCORES-1:0]         req_flat;
   logic signed [DW-1:0]        io_in;
   logic [NCORES-1:0]           in_ack;
   logic [3:0]                  in_port;
   logic [$clog2(FIFO_DEPTH):0] fifo_level;
   logic                        busy;
   logic                        timeout_err;

   multicore_in_dispatch #(
      .NCORES(NCORES), .DW(DW), .FIFO_DEPTH(FIFO_DEPTH), .HOLD(HOLD), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .req_flat(req_flat), .io_in(io_in), .in_ack(in_ack), .in_port(in_port),
      .fifo_level(fifo_level), .busy(busy), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      int                   core;
      logic signed [DW-1:0] data;
      logic [3:0]           port;
   } exp_t;

   exp_t                 exp_q[$];
   logic signed [DW-1:0] model_fifo[$];
   int                   m_ptr;
   int                   pl_cores[$];
   logic [3:0]           pl_codes[$];
   int                   vectors = 0;
   int                   miscompares = 0;

   // Core behaviour: a core with auto_drop releases its request as soon as it sees its ack.
   logic [3:0] req_code [NCORES];
   bit         auto_drop [NCORES];
   int         ack_seen [NCORES];
   int         arm_seen [NCORES];

   always_comb begin
      req_flat = '0;
      for (int k = 0; k < NCORES; k++)
         if (!(auto_drop[k] && ack_seen[k] != arm_seen[k])) req_flat[4*k +: 4] = req_code[k];
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [NCORES-1:0] onehot(input int c);
      logic [NCORES-1:0] v;
      v    = '0;
      v[c] = 1'b1;
      return v;
   endfunction

   logic [NCORES-1:0] prev_ack = '0;
   int                ack_len = 0;
   exp_t              cur_exp;

   always @(negedge clk) begin
      if (!rst) begin
         prev_ack = '0;
         ack_len  = 0;
      end else begin
         if (in_ack != '0) begin
            if (prev_ack == '0) begin
               ack_len = 1;
               for (int k = 0; k < NCORES; k++) if (in_ack[k]) ack_seen[k]++;
               if (exp_q.size() == 0) begin
                  check("unexpected_grant", 64'(in_ack), 64'(0));
               end else begin
                  cur_exp = exp_q.pop_front();
                  check("grant_core", 64'(in_ack), 64'(onehot(cur_exp.core)));
                  check("grant_port", 64'(in_port), 64'(cur_exp.port));
               end
            end else begin
               ack_len++;
               check("ack_stable", 64'(in_ack), 64'(onehot(cur_exp.core)));
            end
            check("grant_data", 64'(io_in), 64'(cur_exp.data));
         end else if (prev_ack != '0) begin
            check("ack_len", 64'(ack_len), 64'(HOLD));
         end
         prev_ack = in_ack;
      end
   end

   task automatic clear_reqs();
      for (int k = 0; k < NCORES; k++) begin
         req_code[k]  = '0;
         auto_drop[k] = 1'b0;
      end
   endtask

   task automatic do_reset(input int cycles);
      #2 rst = 1'b0;
      in_valid = 1'b0;
      clear_reqs();
      model_fifo.delete();
      exp_q.delete();
      m_ptr = 0;
      repeat (cycles) @(negedge clk);
      #2 rst = 1'b1;
      @(negedge clk);
   endtask

   // Called at a negedge with no grant outstanding; returns at the following negedge.
   task automatic push(input logic signed [DW-1:0] d);
      bit acc;
      acc = (model_fifo.size() < FIFO_DEPTH);
      check("in_ready", 64'(in_ready), 64'(acc));
      in_valid = 1'b1;
      in_data  = d;
      @(negedge clk);
      in_valid = 1'b0;
      if (acc) model_fifo.push_back(d);
   endtask

   // Serve order is the requesters sorted by distance from the round-robin pointer.
   task automatic plan_round();
      bit   used [32];
      exp_t e;
      for (int i = 0; i < 32; i++) used[i] = 1'b0;
      for (int n = 0; n < pl_cores.size(); n++) begin
         int best = 0;
         int bd   = NCORES;
         for (int i = 0; i < pl_cores.size(); i++) begin
            int d = (pl_cores[i] - m_ptr + NCORES) % NCORES;
            if (!used[i] && d < bd) begin
               bd   = d;
               best = i;
            end
         end
         used[best] = 1'b1;
         e.core = pl_cores[best];
         e.port = pl_codes[best];
         e.data = model_fifo.pop_front();
         exp_q.push_back(e);
         m_ptr = (pl_cores[best] + 1) % NCORES;
      end
   endtask

   task automatic raise(input int k, input logic [3:0] code, input bit drop);
      arm_seen[k]  = ack_seen[k];
      auto_drop[k] = drop;
      req_code[k]  = code;
   endtask

   task automatic raise_planned(input bit drop);
      for (int i = 0; i < pl_cores.size(); i++) raise(pl_cores[i], pl_codes[i], drop);
   endtask

   task automatic wait_drain(input int budget);
      int n = 0;
      while ((exp_q.size() != 0 || busy) && n < budget) begin
         @(negedge clk);
         n++;
      end
      check("drain_in_time", 64'(exp_q.size() == 0 && !busy), 64'(1));
      clear_reqs();
      @(negedge clk);
   endtask

   task automatic wait_ack(input int k, input int budget);
      int n = 0;
      while (!in_ack[k] && n < budget) begin
         @(negedge clk);
         n++;
      end
      check("ack_arrived", 64'(in_ack[k]), 64'(1));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int c;
      logic signed [DW-1:0] d;
      for (int k = 0; k < NCORES; k++) begin
         req_code[k]  = '0;
         auto_drop[k] = 1'b0;
         ack_seen[k]  = 0;
         arm_seen[k]  = 0;
      end
      m_ptr = 0;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_ack", 64'(in_ack), 64'(0));
      check("rst_io_in", 64'(io_in), 64'(0));
      check("rst_in_ready", 64'(in_ready), 64'(1));
      check("rst_level", 64'(fifo_level), 64'(0));
      check("rst_busy", 64'(busy), 64'(0));
      check("rst_tmo", 64'(timeout_err), 64'(0));
      #2 rst = 1'b1;
      @(negedge clk);

      // Single request: one-cycle latency, HOLD-cycle ack, io_in retained
      push(-19'sd5);
      check("single_level1", 64'(fifo_level), 64'(model_fifo.size()));
      pl_cores = '{3};
      pl_codes = '{4'h2};
      plan_round();
      raise_planned(1'b0);
      @(negedge clk);
      check("single_latency", 64'(in_ack), 64'(onehot(3)));
      check("single_port", 64'(in_port), 64'(2));
      check("single_level0", 64'(fifo_level), 64'(0));
      repeat (HOLD) @(negedge clk);
      check("single_ack_off", 64'(in_ack), 64'(0));
      check("single_busy_rel", 64'(busy), 64'(1));
      check("single_io_kept", 64'(io_in), 64'(-19'sd5));
      req_code[3] = '0;
      @(negedge clk);
      check("single_busy_off", 64'(busy), 64'(0));

      // Round-robin with simultaneous requests, then pointer wrap
      do_reset(3);
      push(19'sd10);
      push(19'sd11);
      push(19'sd12);
      pl_cores = '{0, 7, 24};
      pl_codes = '{4'h1, 4'h9, 4'hF};
      plan_round();
      raise_planned(1'b1);
      wait_drain(200);
      push(19'sd77);
      push(-19'sd77);
      pl_cores = '{24, 0};
      pl_codes = '{4'h3, 4'h4};
      plan_round();
      raise_planned(1'b1);
      wait_drain(200);

      // Randomised rounds
      for (int r = 0; r < 12; r++) begin
         int  ns, nreq, lim;
         bit  taken [NCORES];
         for (int k = 0; k < NCORES; k++) taken[k] = 1'b0;
         ns = $urandom_range(1, 6);
         for (int i = 0; i < ns; i++) begin
            d = DW'($urandom);
            push(d);
         end
         check("rand_level", 64'(fifo_level), 64'(model_fifo.size()));
         lim  = (model_fifo.size() < 6) ? model_fifo.size() : 6;
         nreq = $urandom_range(1, lim);
         pl_cores.delete();
         pl_codes.delete();
         while (pl_cores.size() < nreq) begin
            c = $urandom_range(0, NCORES - 1);
            if (!taken[c]) begin
               taken[c] = 1'b1;
               pl_cores.push_back(c);
               pl_codes.push_back(4'($urandom_range(1, 15)));
            end
         end
         plan_round();
         raise_planned(1'b1);
         wait_drain(400);
      end

      // Empty FIFO holds off grants; full FIFO drops the extra sample
      do_reset(2);
      raise(5, 4'h6, 1'b1);
      repeat (4) begin
         @(negedge clk);
         check("empty_no_ack", 64'(in_ack), 64'(0));
      end
      push(19'sd321);
      check("empty_push_visible", 64'(in_ack), 64'(0));
      pl_cores = '{5};
      pl_codes = '{4'h6};
      plan_round();
      @(negedge clk);
      check("empty_then_ack", 64'(in_ack), 64'(onehot(5)));
      wait_drain(100);
      for (int i = 0; i < FIFO_DEPTH + 1; i++) push(DW'(i * 3 - 20));
      check("full_level", 64'(fifo_level), 64'(FIFO_DEPTH));
      check("full_not_ready", 64'(in_ready), 64'(0));

      // Reset during GRANT discards everything at once
      do_reset(2);
      push(19'sd1000);
      push(19'sd2000);
      pl_cores = '{9};
      pl_codes = '{4'h7};
      plan_round();
      raise_planned(1'b0);
      wait_ack(9, 10);
      #2 rst = 1'b0;
      #1;
      check("midrst_ack", 64'(in_ack), 64'(0));
      check("midrst_level", 64'(fifo_level), 64'(0));
      check("midrst_busy", 64'(busy), 64'(0));
      check("midrst_io_in", 64'(io_in), 64'(0));
      do_reset(2);

      // Held request after service
      push(19'sd555);
      push(19'sd666);
      pl_cores = '{2, 20};
      pl_codes = '{4'hA, 4'hB};
      plan_round();
      raise(2, 4'hA, 1'b0);
      raise(20, 4'hB, 1'b1);
      wait_ack(2, 10);
      repeat (HOLD) @(negedge clk);
      check("held_ack_off", 64'(in_ack), 64'(0));
`ifdef MULTICORE_IN_TIMEOUT_EN
      repeat (TIMEOUT - 1) @(negedge clk);
      check("tmo_not_yet", 64'(timeout_err), 64'(0));
      @(negedge clk);
      check("tmo_set", 64'(timeout_err), 64'(1));
      wait_drain(100);
      check("tmo_sticky", 64'(timeout_err), 64'(1));
`else
      for (int i = 0; i < 4; i++) begin
         repeat (20) @(negedge clk);
         check("held_busy", 64'(busy), 64'(1));
      end
      check("held_no_tmo", 64'(timeout_err), 64'(0));
      req_code[2] = '0;
      wait_drain(100);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
